// File: rtl/sum_it_up_gen_if.sv
// Bus bundle for sum_it_up_gen: operand stream and start request in,
// reduction status and results out. Clock and reset stay outside.
interface sum_it_up_gen_if #(
   parameter int W  = 8,
   parameter int SW = 12,
   parameter int CW = 8
);
   logic          go_l;
   logic [1:0]    mode;
   logic [W-1:0]  inA;
   logic          busy;
   logic          done;
   logic [SW-1:0] result;
   logic [CW-1:0] count;
   logic          overflow;

   // Value source / test driver side
   modport master (
      output go_l, mode, inA,
      input  busy, done, result, count, overflow
   );

   // Reduction engine side
   modport slave (
      input  go_l, mode, inA,
      output busy, done, result, count, overflow
   );
endinterface

// File: rtl/sum_it_up_gen.sv
// Serial list reducer. After an active-low go it consumes one operand per
// clock until a zero terminator or MAXN operands, folding them with
// SUM / MAX / MIN / COUNT, then pulses done with a held result.
module sum_it_up_gen #(
   parameter int W    = 8,
   parameter int SW   = 12,
   parameter int MAXN = 255,
   parameter int CW   = 8
) (
   input  logic           ck,
   input  logic           reset_l,
   sum_it_up_gen_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [1:0] M_SUM   = 2'd0;
   localparam logic [1:0] M_MAX   = 2'd1;
   localparam logic [1:0] M_MIN   = 2'd2;
   localparam logic [1:0] M_COUNT = 2'd3;

   localparam logic [CW-1:0] MAXN_C   = CW'(MAXN);
   localparam logic [SW-1:0] ACC_ONES = '1;

   state_t        r_state;
   state_t        w_state_next;
   logic [1:0]    r_mode;
   logic [SW-1:0] r_acc;
   logic [CW-1:0] r_count;
   logic          r_overflow;

   // Accept cycle: IDLE with go_l asserted. The operand on inA in this
   // same cycle is already the first list element.
   logic          w_accept;
   logic          w_take;
   logic          w_nonzero;
   logic          w_fold;
   logic          w_first;
   logic          w_hit_max;
   logic          w_last;
   logic [1:0]    w_mode_eff;
   logic [SW-1:0] w_acc_base;
   logic          w_ovf_base;
   logic [CW-1:0] w_count_base;
   logic [CW-1:0] w_count_inc;
   logic [SW-1:0] w_op;
   logic [SW:0]   w_sum;
   logic [SW-1:0] w_acc_fold;
   logic          w_ovf_fold;
   logic [1:0]    w_mode_next;
   logic [SW-1:0] w_acc_next;
   logic [CW-1:0] w_count_next;
   logic          w_ovf_next;

   assign w_accept  = (r_state == S_IDLE) && !bus.go_l;
   assign w_take    = w_accept || (r_state == S_RUN);
   assign w_nonzero = (bus.inA != '0);
   assign w_fold    = w_take && w_nonzero;
   assign w_first   = w_accept;

   // The mode input only matters in the accept cycle; afterwards the
   // latched copy governs the rest of the list.
   assign w_mode_eff = w_accept ? bus.mode : r_mode;

   // On accept the previous list's state is discarded, so the fold starts
   // from a clean accumulator, counter and overflow flag.
   assign w_acc_base   = w_accept ? '0   : r_acc;
   assign w_ovf_base   = w_accept ? 1'b0 : r_overflow;
   assign w_count_base = w_accept ? '0   : r_count;
   assign w_count_inc  = w_count_base + 1'b1;

   // Operands are unsigned and zero-extended to the result width.
   assign w_op  = SW'(bus.inA);
   assign w_sum = {1'b0, w_acc_base} + {1'b0, w_op};

   // The list ends on a zero operand, or when this operand is the MAXN-th.
   assign w_hit_max = w_fold && (w_count_inc == MAXN_C);
   assign w_last    = (w_take && !w_nonzero) || w_hit_max;

   // Fold one nonzero operand into the accumulator under the effective mode
   always_comb begin
      w_acc_fold = w_acc_base;
      w_ovf_fold = w_ovf_base;
      case (w_mode_eff)
         M_SUM: begin
            // Saturate on carry-out; once saturated every further nonzero
            // operand carries again, so the accumulator stays at all-ones.
            if (w_sum[SW]) begin
               w_acc_fold = ACC_ONES;
               w_ovf_fold = 1'b1;
            end else begin
               w_acc_fold = w_sum[SW-1:0];
            end
         end
         M_MAX: begin
            if (w_first || (w_op > w_acc_base)) begin
               w_acc_fold = w_op;
            end
         end
         M_MIN: begin
            // The first operand loads directly, so no all-ones seed is
            // ever needed or visible on result.
            if (w_first || (w_op < w_acc_base)) begin
               w_acc_fold = w_op;
            end
         end
         M_COUNT: begin
            w_acc_fold = SW'(w_count_inc);
         end
         default: begin
            w_acc_fold = w_acc_base;
         end
      endcase
   end

   // Datapath next values: clear on accept, fold on every nonzero operand
   always_comb begin
      w_mode_next  = r_mode;
      w_acc_next   = r_acc;
      w_count_next = r_count;
      w_ovf_next   = r_overflow;
      if (w_accept) begin
         w_mode_next  = bus.mode;
         w_acc_next   = '0;
         w_count_next = '0;
         w_ovf_next   = 1'b0;
      end
      if (w_fold) begin
         w_acc_next   = w_acc_fold;
         w_count_next = w_count_inc;
         w_ovf_next   = w_ovf_fold;
      end
   end

   // FSM state register
   always_ff @(posedge ck or negedge reset_l) begin
      if (!reset_l) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_next = w_last ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (w_last) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            // Always exactly one DONE cycle; a held go_l is picked up in
            // the following IDLE cycle.
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // FSM outputs: busy across RUN and DONE, done only in DONE
   always_comb begin
      bus.busy = 1'b0;
      bus.done = 1'b0;
      case (r_state)
         S_RUN: begin
            bus.busy = 1'b1;
         end
         S_DONE: begin
            bus.busy = 1'b1;
            bus.done = 1'b1;
         end
         default: begin
            bus.busy = 1'b0;
            bus.done = 1'b0;
         end
      endcase
   end

   // Datapath registers: latched mode, accumulator, count, sticky overflow
   always_ff @(posedge ck or negedge reset_l) begin
      if (!reset_l) begin
         r_mode     <= M_SUM;
         r_acc      <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_mode     <= w_mode_next;
         r_acc      <= w_acc_next;
         r_count    <= w_count_next;
         r_overflow <= w_ovf_next;
      end
   end

   // Result outputs come straight from registers, so they are stable in
   // the DONE cycle and held through IDLE until the next accept.
   assign bus.result   = r_acc;
   assign bus.count    = r_count;
   assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_sum_it_up_gen.sv
// Directed bench for sum_it_up_gen: default build (SW=12), a saturation
// build (SW=8) and a short-list build (MAXN=4), all sharing clock/reset.
`define CHK(tag, obs, exp) \
   begin \
      checks++; \
      assert ((obs) === (exp)) else begin \
         failures++; \
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp); \
      end \
   end

module tb_sum_it_up_gen;

   logic ck;
   logic reset_l;
   int   checks;
   int   failures;
   bit   test_finished;

   sum_it_up_gen_if #(.W(8), .SW(12), .CW(8)) ifa ();
   sum_it_up_gen_if #(.W(8), .SW(8),  .CW(8)) ifb ();
   sum_it_up_gen_if #(.W(8), .SW(12), .CW(8)) ifc ();

   sum_it_up_gen #(.W(8), .SW(12), .MAXN(255), .CW(8)) dut_a (
      .ck(ck), .reset_l(reset_l), .bus(ifa)
   );
   sum_it_up_gen #(.W(8), .SW(8), .MAXN(255), .CW(8)) dut_b (
      .ck(ck), .reset_l(reset_l), .bus(ifb)
   );
   sum_it_up_gen #(.W(8), .SW(12), .MAXN(4), .CW(8)) dut_c (
      .ck(ck), .reset_l(reset_l), .bus(ifc)
   );

   initial ck = 1'b0;
   always #5 ck = ~ck;

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge ck);
      #1;
   endtask

   // Reset-state comparison: all outputs at their reset values
   task automatic check_reset_state(input string tag);
      checks++;
      if (ifa.busy !== 1'b0 || ifa.done !== 1'b0 || ifa.result !== 12'd0 ||
          ifa.count !== 8'd0 || ifa.overflow !== 1'b0) begin
         failures++;
         $error("FAIL %s busy=%0b done=%0b result=%0d count=%0d overflow=%0b",
                tag, ifa.busy, ifa.done, ifa.result, ifa.count, ifa.overflow);
      end else begin
         $display("check %s: reset state ok", tag);
      end
   endtask

   // Expired-wait check: the directed sequence must finish within budget
   initial begin : watchdog
      int cycles;
      cycles = 0;
      while (!test_finished && cycles < 2000) begin
         @(posedge ck);
         cycles++;
      end
      if (!test_finished) begin
         checks++;
         failures++;
         $error("FAIL timeout: test did not finish within %0d cycles", cycles);
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $finish;
      end
   end

   initial begin
      checks        = 0;
      failures      = 0;
      test_finished = 1'b0;
      reset_l  = 1'b0;
      ifa.go_l = 1'b1; ifa.mode = 2'd0; ifa.inA = 8'd0;
      ifb.go_l = 1'b1; ifb.mode = 2'd0; ifb.inA = 8'd0;
      ifc.go_l = 1'b1; ifc.mode = 2'd0; ifc.inA = 8'd0;

      // Reset state
      tick();
      tick();
      check_reset_state("rst_state");
      `CHK("rst_busy",   ifa.busy,     1'b0)
      `CHK("rst_done",   ifa.done,     1'b0)
      `CHK("rst_result", ifa.result,   12'd0)
      `CHK("rst_count",  ifa.count,    8'd0)
      `CHK("rst_ovf",    ifa.overflow, 1'b0)
      reset_l = 1'b1;
      tick();
      `CHK("idle_busy", ifa.busy, 1'b0)

      // SUM 5,7,3,0 -> 15
      ifa.go_l = 1'b0; ifa.mode = 2'd0; ifa.inA = 8'd5;
      tick();
      `CHK("sum_accept_busy", ifa.busy, 1'b1)
      `CHK("sum_accept_done", ifa.done, 1'b0)
      ifa.go_l = 1'b1; ifa.inA = 8'd7;
      tick();
      ifa.inA = 8'd3;
      tick();
      `CHK("sum_run_done", ifa.done, 1'b0)
      ifa.inA = 8'd0;
      tick();
      `CHK("sum_done",   ifa.done,     1'b1)
      `CHK("sum_result", ifa.result,   12'd15)
      `CHK("sum_count",  ifa.count,    8'd3)
      `CHK("sum_ovf",    ifa.overflow, 1'b0)
      $display("list SUM 5,7,3: result=%0d count=%0d overflow=%0d", ifa.result, ifa.count, ifa.overflow);
      tick();
      `CHK("sum_after_done", ifa.done,   1'b0)
      `CHK("sum_after_busy", ifa.busy,   1'b0)
      `CHK("sum_held",       ifa.result, 12'd15)

      // SUM saturation on SW=8 build: 200,100,0 -> 255, overflow
      ifb.go_l = 1'b0; ifb.mode = 2'd0; ifb.inA = 8'd200;
      tick();
      ifb.go_l = 1'b1; ifb.inA = 8'd100;
      tick();
      ifb.inA = 8'd0;
      tick();
      `CHK("sat_done",   ifb.done,     1'b1)
      `CHK("sat_result", ifb.result,   8'd255)
      `CHK("sat_ovf",    ifb.overflow, 1'b1)
      `CHK("sat_count",  ifb.count,    8'd2)
      $display("list SUM 200,100 (SW=8): result=%0d count=%0d overflow=%0d", ifb.result, ifb.count, ifb.overflow);
      tick();

      // MAX then MIN back-to-back with go_l held low; mode toggled mid-list
      ifa.go_l = 1'b0; ifa.mode = 2'd1; ifa.inA = 8'd9;
      tick();
      ifa.mode = 2'd2; ifa.inA = 8'd2;
      tick();
      ifa.inA = 8'd14;
      tick();
      ifa.inA = 8'd0;
      tick();
      `CHK("max_done",   ifa.done,   1'b1)
      `CHK("max_result", ifa.result, 12'd14)
      `CHK("max_count",  ifa.count,  8'd3)
      $display("list MAX 9,2,14: result=%0d count=%0d", ifa.result, ifa.count);
      ifa.inA = 8'd9;
      tick();
      `CHK("b2b_idle_busy", ifa.busy,   1'b0)
      `CHK("b2b_idle_done", ifa.done,   1'b0)
      `CHK("b2b_idle_held", ifa.result, 12'd14)
      tick();
      `CHK("b2b_accept_busy", ifa.busy, 1'b1)
      ifa.inA = 8'd2;
      tick();
      ifa.inA = 8'd14;
      tick();
      ifa.go_l = 1'b1; ifa.inA = 8'd0;
      tick();
      `CHK("min_done",   ifa.done,   1'b1)
      `CHK("min_result", ifa.result, 12'd2)
      `CHK("min_ovf",    ifa.overflow, 1'b0)
      $display("list MIN 9,2,14: result=%0d count=%0d", ifa.result, ifa.count);
      tick();

      // Empty list
      ifa.go_l = 1'b0; ifa.mode = 2'd1; ifa.inA = 8'd0;
      tick();
      `CHK("empty_done",   ifa.done,     1'b1)
      `CHK("empty_result", ifa.result,   12'd0)
      `CHK("empty_count",  ifa.count,    8'd0)
      `CHK("empty_ovf",    ifa.overflow, 1'b0)
      $display("list empty: result=%0d count=%0d", ifa.result, ifa.count);
      ifa.go_l = 1'b1;
      tick();
      `CHK("empty_after_done", ifa.done, 1'b0)

      // COUNT 1,1,1,1,0 -> 4
      ifa.go_l = 1'b0; ifa.mode = 2'd3; ifa.inA = 8'd1;
      tick();
      ifa.go_l = 1'b1; ifa.mode = 2'd0;
      tick();
      tick();
      tick();
      ifa.inA = 8'd0;
      tick();
      `CHK("count_done",   ifa.done,   1'b1)
      `CHK("count_result", ifa.result, 12'd4)
      `CHK("count_count",  ifa.count,  8'd4)
      $display("list COUNT 1,1,1,1: result=%0d count=%0d", ifa.result, ifa.count);
      tick();

      // MAXN=4 build: 1,2,3,4 terminates, 5 and 6 ignored
      ifc.go_l = 1'b0; ifc.mode = 2'd0; ifc.inA = 8'd1;
      tick();
      ifc.go_l = 1'b1; ifc.inA = 8'd2;
      tick();
      ifc.inA = 8'd3;
      tick();
      ifc.inA = 8'd4;
      tick();
      `CHK("maxn_done",   ifc.done,   1'b1)
      `CHK("maxn_result", ifc.result, 12'd10)
      `CHK("maxn_count",  ifc.count,  8'd4)
      $display("list SUM 1,2,3,4 (MAXN=4): result=%0d count=%0d", ifc.result, ifc.count);
      ifc.inA = 8'd5;
      tick();
      `CHK("maxn_after_done", ifc.done,   1'b0)
      `CHK("maxn_ignore5",    ifc.result, 12'd10)
      ifc.inA = 8'd6;
      tick();
      `CHK("maxn_ignore6_busy", ifc.busy,   1'b0)
      `CHK("maxn_ignore6",      ifc.result, 12'd10)
      ifc.go_l = 1'b0; ifc.inA = 8'd7;
      tick();
      ifc.go_l = 1'b1; ifc.inA = 8'd0;
      tick();
      `CHK("maxn_next_result", ifc.result, 12'd7)
      `CHK("maxn_next_count",  ifc.count,  8'd1)
      $display("list SUM 7 (MAXN=4): result=%0d count=%0d", ifc.result, ifc.count);
      tick();

      // Async reset mid-RUN after three operands
      ifa.go_l = 1'b0; ifa.mode = 2'd0; ifa.inA = 8'd4;
      tick();
      ifa.go_l = 1'b1;
      tick();
      tick();
      `CHK("pre_reset_result", ifa.result, 12'd12)
      #2;
      reset_l = 1'b0;
      #1;
      `CHK("arst_busy",   ifa.busy,   1'b0)
      `CHK("arst_result", ifa.result, 12'd0)
      `CHK("arst_count",  ifa.count,  8'd0)
      `CHK("arst_done",   ifa.done,   1'b0)
      check_reset_state("arst_state");
      tick();
      `CHK("arst_no_done", ifa.done, 1'b0)
      reset_l = 1'b1;
      ifa.go_l = 1'b0; ifa.inA = 8'd4;
      tick();
      ifa.go_l = 1'b1; ifa.inA = 8'd0;
      tick();
      `CHK("post_reset_done",   ifa.done,   1'b1)
      `CHK("post_reset_result", ifa.result, 12'd4)
      $display("list SUM 4 after reset: result=%0d count=%0d", ifa.result, ifa.count);
      tick();

      test_finished = 1'b1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sum_it_up_gen.md
Name: sum_it_up_gen

Overview:
Parametrised successor to the serial-sum thread. After an active-low go, it consumes one operand per clock from `inA` until a zero terminator arrives or an operand limit is reached. It then reduces the operands according to a selectable mode (sum, max, min, count) and signals `done` with a held `result`. It sits between the testbench value source and the downstream accumulator, which loads `result` when `done` is high.

Parameters:
W, 8, operand width of `inA`
SW, 12, `result` width; must satisfy SW >= W
MAXN, 255, maximum operands per list; reaching it forces termination
CW, 8, `count` width; must satisfy 2^CW-1 >= MAXN

Ports:
ck  input  1  clock, rising-edge
reset_l  input  1  asynchronous active-low reset
go_l  input  1  active-low start request; sampled in IDLE only
mode  input  2  0=SUM, 1=MAX, 2=MIN, 3=COUNT; captured at go acceptance
inA  input  W  operand stream, unsigned; value 0 terminates the list
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse; result/count/overflow valid
result  output  SW  reduction result, held until next go accepted
count  output  CW  number of nonzero operands consumed
overflow  output  1  sticky: SUM exceeded 2^SW-1 during this list

Behaviour:
- Reset (async, reset_l=0): state=IDLE; busy=0, done=0, result=0, count=0, overflow=0; latched mode=SUM.
- States: IDLE, RUN, DONE.
- IDLE, go_l=1: hold all outputs.
- IDLE, go_l=0 (accept):
  - latch mode; clear count, overflow and the accumulator.
  - `inA` in the accept cycle is the first operand.
  - inA==0 -> DONE (empty list).
  - inA!=0 -> fold the operand, count=1, go to RUN. If MAXN==1, go directly to DONE.
- RUN, each cycle:
  - inA==0 -> DONE; the zero is not folded.
  - inA!=0 -> fold the operand, count+=1.
  - If count reaches MAXN with this operand -> DONE; the next `inA` is ignored.
  - go_l is ignored in RUN.
- DONE: done=1 for exactly one cycle, then IDLE. `result`, `count` and `overflow` are stable in the DONE cycle and held through IDLE.
- Latency: done rises on the clock edge after the terminating zero (or MAXN-th operand) is sampled.
- Folding, with operands zero-extended to SW:
  - SUM: acc=acc+inA, computed SW+1 wide. On carry: overflow=1 and acc=all-ones (saturate); it stays saturated.
  - MAX: acc=max(acc,inA). The first operand loads directly.
  - MIN: acc=min(acc,inA). The first operand loads directly (no all-ones seed visible).
  - COUNT: result=count, zero-extended/truncated to SW.
- Empty list: result=0, count=0, overflow=0 in every mode; done still pulses.
- overflow is only set in SUM mode.
- go_l held low across DONE->IDLE: a new list is accepted in the first IDLE cycle (back-to-back lists, one idle cycle between done and next accept).
- Reset mid-RUN or mid-DONE: immediate return to reset values; no done pulse is emitted.
- `mode` changes outside the accept cycle have no effect on the current list.

Test Plan:
- SUM, W=8 SW=12: go_l=0 with inA=5, then 7, 3, 0 -> done one cycle after 0 sampled; result=15, count=3, overflow=0, busy low the following cycle.
- SUM saturation, SW=8 build: operands 200, 100, 0 -> result=255, overflow=1, count=2.
- MAX then MIN back-to-back, go_l held low: list 9, 2, 14, 0 in MAX -> result=14. Next accept in MIN with 9, 2, 14, 0 -> result=2. Exactly one idle cycle between the two done pulses.
- Empty list and COUNT mode: go_l=0 with inA=0 -> done next cycle, result=0, count=0. COUNT list 1, 1, 1, 1, 0 -> result=4.
- MAXN=4 build: operands 1, 2, 3, 4, 5, 6 without zero -> done after the 4th; result=10, count=4; the 5 and 6 are ignored. Next list starts clean.
- Async reset: pull reset_l low mid-RUN after 3 operands (between edges) -> outputs zero immediately, no done pulse. A following list 4, 0 gives result=4.
